// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode. Holds {instruction, PC+4} pairs,
// drops everything on a taken branch, and shows a NOP to decode when empty.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_instruction,
    input  logic [WIDTH-1:0]           in_incremented_pc,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_instruction,
    output logic [WIDTH-1:0]           out_incremented_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem    [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Readiness depends on registered count only, so a full queue refuses a push
    // even when decode pops in the same cycle.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    assign out_instruction    = out_valid ? instr_mem[rd_ptr_q] : '0;
    assign out_incremented_pc = out_valid ? pc_mem[rd_ptr_q]    : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Incoming fetch is wrong-path; discard it along with the buffered entries.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            instr_mem[wr_ptr_q] <= in_instruction;
            pc_mem[wr_ptr_q]    <= in_incremented_pc;
        end
    end

endmodule
